// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and majority voting, feeding a show-ahead FIFO.
// Framing and overrun errors are reported through sticky flags cleared by err_clr.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               rxd,
  input  logic                               rd_en,
  input  logic                               err_clr,
  output logic [7:0]                         rd_data,
  output logic                               empty,
  output logic                               full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                               frame_err,
  output logic                               overrun
);

  localparam int DIV   = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic             sync1;
  logic             rxs;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [2:0]       state;
  logic [3:0]       os;
  logic [2:0]       bit_idx;
  logic             s7;
  logic             s8;
  logic [7:0]       shift;
  logic             bit_val;
  logic             resolve;
  logic             stop_ok;
  logic             push;
  logic             pop;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [7:0]       mem [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (((state == IDLE) && !rxs) || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + DIV_W'(1);
  end

  // Samples are taken on the ticks that move os to 7 and 8; the third vote is the
  // live rxs on the tick that moves os to 9, which is where the bit resolves.
  assign bit_val = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign resolve = tick && (os == 4'd8);
  assign stop_ok = (state == STOP) && resolve && bit_val;
  assign push    = stop_ok && (!full || rd_en);
  assign pop     = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      os      <= 4'd0;
      bit_idx <= 3'd0;
      s7      <= 1'b1;
      s8      <= 1'b1;
      shift   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            os    <= 4'd0;
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: begin
          if (tick) begin
            os <= os + 4'd1;
            if (os == 4'd6) s7 <= rxs;
            if (os == 4'd7) s8 <= rxs;
            case (state)
              START: begin
                if (resolve && bit_val) begin
                  state <= IDLE;
                end else if (os == 4'd15) begin
                  state   <= DATA;
                  bit_idx <= 3'd0;
                end
              end
              DATA: begin
                if (resolve) shift <= {bit_val, shift[7:1]};
                if (os == 4'd15) begin
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
                end
              end
              STOP: begin
                // Leaving early at the resolve lets a back-to-back start edge be caught.
                if (resolve) state <= bit_val ? IDLE : WAIT_HIGH;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if ((state == STOP) && resolve && !bit_val) frame_err <= 1'b1;
      else if (err_clr)                           frame_err <= 1'b0;
      if (stop_ok && full && !rd_en) overrun <= 1'b1;
      else if (err_clr)              overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo; runs at 781250 baud (DIV=8, 128 clocks per bit)
// so the full sequence fits in a modest number of cycles.
module tb_uart_rx_fifo;

  localparam int BIT = 128;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       frame_err;
  logic       overrun;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int t_start = 0;
  int t_empty = 0;
  logic empty_q = 1'b1;
  logic [7:0] model [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ  (100_000_000),
    .BAUD      (781_250),
    .FIFO_DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rd_en    (rd_en),
    .err_clr  (err_clr),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (empty_q === 1'b1 && empty === 1'b0) t_empty <= cyc;
    empty_q <= empty;
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: observed no finish, required finish within 150000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_data(input logic [7:0] b);
    @(negedge clk);
    rxd = 1'b0;
    t_start = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_data(b);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    exp = model.pop_front();
    check(tag, rd_data, exp);
    pop_one();
  endtask

  initial begin
    logic [7:0] b;
    int n;
    int lat;

    rst_n = 1'b0; rxd = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte: 3 sync/detect clocks + 153 ticks of 8 clocks = 1227.
    send_frame(8'hA5);
    lat = t_empty - t_start;
    check("a5_latency_1225_to_1229", (lat >= 1225 && lat <= 1229), 1'b1);
    check("a5_rd_data", rd_data, 8'hA5);
    check("a5_count", count, 4'd1);
    check("a5_full", full, 1'b0);
    check("a5_frame_err", frame_err, 1'b0);
    check("a5_overrun", overrun, 1'b0);
    pop_one();
    check("a5_pop_empty", empty, 1'b1);
    check("a5_pop_count", count, 4'd0);

    // Glitch shorter than half a bit.
    @(negedge clk);
    rxd = 1'b0;
    repeat (45) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_empty", empty, 1'b1);
    check("glitch_frame_err", frame_err, 1'b0);
    send_frame(8'h3C);
    check("after_glitch_data", rd_data, 8'h3C);
    check("after_glitch_count", count, 4'd1);
    pop_one();

    // Framing error with a stop bit held low for two bit periods.
    send_data(8'h55);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    check("fe_set", frame_err, 1'b1);
    check("fe_empty", empty, 1'b1);
    pulse_clr();
    check("fe_cleared", frame_err, 1'b0);
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (10 * BIT) @(negedge clk);
    check("fe_single_error", frame_err, 1'b0);
    check("fe_nothing_pushed", empty, 1'b1);
    send_frame(8'h12);
    check("after_fe_data", rd_data, 8'h12);
    check("after_fe_count", count, 4'd1);
    pop_one();

    // Overrun: nine bytes with no reads.
    for (int i = 0; i < 9; i++) send_frame(8'(i));
    check("ovr_full", full, 1'b1);
    check("ovr_count", count, 4'd8);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_frame_err", frame_err, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("ovr_drain_data", rd_data, 8'(i));
      pop_one();
    end
    check("ovr_drained_empty", empty, 1'b1);
    pulse_clr();
    check("ovr_cleared", overrun, 1'b0);

    // Full boundary: a read in the stop-resolve cycle lets the ninth byte in.
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i));
    check("refill_full", full, 1'b1);
    fork
      send_frame(8'h09);
      begin
        repeat (1227) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    check("boundary_count", count, 4'd8);
    check("boundary_full", full, 1'b1);
    check("boundary_overrun", overrun, 1'b0);
    for (int i = 1; i < 8; i++) begin
      check("boundary_drain_data", rd_data, 8'h10 + 8'(i));
      pop_one();
    end
    check("boundary_last_data", rd_data, 8'h09);
    pop_one();
    check("boundary_empty", empty, 1'b1);

    // Pointer wrap with random traffic.
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      if (model.size() == 8) pop_check("rand_data");
      send_frame(b);
      model.push_back(b);
      check("rand_count", count, 4'(model.size()));
      check("rand_empty", empty, model.size() == 0);
      check("rand_full", full, model.size() == 8);
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) if (model.size() > 0) pop_check("rand_data");
    end
    while (model.size() > 0) pop_check("rand_data");
    check("rand_final_empty", empty, 1'b1);
    check("rand_overrun", overrun, 1'b0);

    // Reset during data bit 4 of 0xF0 with one byte already queued.
    send_frame(8'h77);
    check("pre_rst_count", count, 4'd1);
    fork
      send_frame(8'hF0);
      begin
        repeat (1 + 5 * BIT + BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_rd_data", rd_data, 8'h00);
        check("midrst_empty", empty, 1'b1);
        check("midrst_full", full, 1'b0);
        check("midrst_count", count, 4'd0);
        check("midrst_frame_err", frame_err, 1'b0);
        check("midrst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
      end
    join
    repeat (BIT) @(negedge clk);
    check("midrst_no_partial", empty, 1'b1);
    send_frame(8'h81);
    check("after_rst_data", rd_data, 8'h81);
    check("after_rst_count", count, 4'd1);
    pop_one();
    check("after_rst_empty", empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
